// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Holds the FSM state type, the MIPS register-field width and the zero-register constant.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 6;
  localparam int FUNCT_W    = 6;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when a load in ID/EX writes a register that the IF/ID instruction reads.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  // $zero never carries a real dependency, so a load targeting it is ignored
  always_comb begin
    hazard = ex_memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: post-reset fill, load-use stalls,
// taken-branch flushes and data-memory wait states, driving PC and latch enables/clears.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int WAIT_MAX    = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  mem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  pipe_hold,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  ctrl_state_t       state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_set;
  logic              load_use;
  logic              mem_stall;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .hazard     (load_use)
  );

  // An outstanding access stalls in RUN only when requested; in MEM_WAIT it stalls until ready
  always_comb begin
    mem_stall = !mem_ready &&
                ((state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && mem_req));
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_set  = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = ST_MEM_WAIT;
          if (state_q == ST_RUN) begin
            wait_cnt_d = WAIT_ONE;
          end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          timeout_set = (wait_cnt_d == WAIT_LIMIT);
        end else begin
          // Release cycle of a wait behaves exactly like RUN, so a queued branch or hazard acts now
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end

      default: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = ST_INIT;
        init_cnt_d   = '0;
        wait_cnt_d   = '0;
      end
    endcase
  end

  // Reset drops any pending wait; the memory side is expected to tolerate the lost request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if ((state_q != ST_INIT) && !pc_write && (stall_count != CNT_SAT)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of per-cycle vectors plus
// hand-written wait/timeout/reset sequences, compared through an expected-value queue.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        mem_branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic        pipe_hold, mem_timeout;
  logic [15:0] stall_count;

  int assert_count = 0;
  int fail_count   = 0;

  // Control patterns: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
  localparam logic [5:0] C_INIT = 6'b00_111_0;
  localparam logic [5:0] C_RUN  = 6'b11_000_0;
  localparam logic [5:0] C_LU   = 6'b00_010_0;
  localparam logic [5:0] C_BR   = 6'b11_111_0;
  localparam logic [5:0] C_HOLD = 6'b00_000_1;

  typedef struct {
    string       name;
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        memread;
    logic [4:0]  ex_rt;
    logic        br;
    logic        req;
    logic        rdy;
    logic [5:0]  exp_ctrl;
    logic        exp_to;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (4),
    .WAIT_MAX    (4),
    .CNT_W       (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_memread       (ex_memread),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .pipe_hold        (pipe_hold),
    .mem_timeout      (mem_timeout),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic [4:0] rs,
                              input logic [4:0] rt, input logic uses_rt, input logic memread,
                              input logic [4:0] ert, input logic br, input logic req,
                              input logic rdy, input logic [5:0] ctrl, input logic to,
                              input logic [15:0] stall);
    vec_t v;
    v.name = name; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
    v.memread = memread; v.ex_rt = ert; v.br = br; v.req = req; v.rdy = rdy;
    v.exp_ctrl = ctrl; v.exp_to = to; v.exp_stall = stall;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst              = v.rst;
    id_rs            = v.rs;
    id_rt            = v.rt;
    id_uses_rt       = v.uses_rt;
    ex_memread       = v.memread;
    ex_rt            = v.ex_rt;
    mem_branch_taken = v.br;
    mem_req          = v.req;
    mem_ready        = v.rdy;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t       e;
    logic [6:0] got;
    logic [6:0] want;
    assert_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    e    = exp_q.pop_front();
    got  = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, mem_timeout};
    want = {e.exp_ctrl, e.exp_to};
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s ctrl: got %b expected %b (pc,ifid,iff,idf,exf,hold,to)",
               e.name, got, want);
    end
    assert_count++;
    if (stall_count !== e.exp_stall) begin
      fail_count++;
      $display("[TB] FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.exp_stall);
    end
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    //              name        rst rs    rt    urt mrd exrt  br req rdy  ctrl    to stall
    tbl[0]  = mk("reset0",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[1]  = mk("reset1",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[2]  = mk("init1",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[3]  = mk("init2",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[4]  = mk("init3",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[5]  = mk("init4",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0);
    tbl[6]  = mk("run_first",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  0, 16'd0);
    tbl[7]  = mk("lu_rs",      0, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, C_LU,   0, 16'd0);
    tbl[8]  = mk("after_lu",   0, 5'd8, 5'd2, 0, 0, 5'd8, 0, 0, 0, C_RUN,  0, 16'd1);
    tbl[9]  = mk("lu_zero",    0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, C_RUN,  0, 16'd1);
    tbl[10] = mk("rt_unused",  0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 0, C_RUN,  0, 16'd1);
    tbl[11] = mk("lu_rt",      0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 0, C_LU,   0, 16'd1);
    tbl[12] = mk("after_rt",   0, 5'd3, 5'd9, 1, 0, 5'd9, 0, 0, 0, C_RUN,  0, 16'd2);
    tbl[13] = mk("no_load",    0, 5'd8, 5'd0, 0, 0, 5'd8, 0, 0, 0, C_RUN,  0, 16'd2);
    tbl[14] = mk("br_over_lu", 0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0, C_BR,   0, 16'd2);
    tbl[15] = mk("after_br",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  0, 16'd2);

    for (int i = 0; i < 16; i++) begin
      run(tbl[i]);
    end

    // Memory wait with a branch queued behind it: flush only on the release cycle
    run(mk("wait_br1",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, C_HOLD, 0, 16'd2));
    run(mk("wait_br2",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, C_HOLD, 0, 16'd3));
    run(mk("wait_br3",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, C_HOLD, 0, 16'd4));
    run(mk("release_br", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, C_BR,   0, 16'd5));
    run(mk("post_br",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  0, 16'd5));

    // Load-use pending behind an access is honoured on release
    run(mk("wait_lu1",   0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 0, C_HOLD, 0, 16'd5));
    run(mk("release_lu", 0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 1, C_LU,   0, 16'd6));
    run(mk("post_lu",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  0, 16'd7));
    run(mk("req_ready",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_RUN,  0, 16'd7));

    // Six-cycle wait against WAIT_MAX=4: timeout visible after the fourth wait cycle, sticky
    run(mk("to_w1",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 0, 16'd7));
    run(mk("to_w2",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 0, 16'd8));
    run(mk("to_w3",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 0, 16'd9));
    run(mk("to_w4",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 0, 16'd10));
    run(mk("to_w5",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 1, 16'd11));
    run(mk("to_w6",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 1, 16'd12));
    run(mk("to_release", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_RUN,  1, 16'd13));
    run(mk("to_sticky",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  1, 16'd13));

    // Reset in the middle of a wait abandons it and clears the sticky flag
    run(mk("rw_w1",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 1, 16'd13));
    run(mk("rw_rst",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_HOLD, 1, 16'd14));
    run(mk("rw_init1",   0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1, 0, C_INIT, 0, 16'd0));
    run(mk("rw_init2",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0));
    run(mk("rw_init3",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, C_INIT, 0, 16'd0));
    run(mk("rw_init4",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_INIT, 0, 16'd0));
    run(mk("rw_run",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_RUN,  0, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
